bus_rx_endpoint: RTL and testbench
==================================

// Module: bus_rx_endpoint
// PURPOSE
//  Receive-side endpoint of the shared bus; one instance per driver port.
//  Samples push/D_push from bs_gnrtr_n_rbtr and keeps only packets whose
//  destination ID matches this port or the broadcast ID.
//  Buffers accepted packets in a FIFO and hands them to a local consumer
//  over a valid/ready handshake.
//  The bus has no backpressure on push, so overflow drops packets and
//  raises a sticky flag.
// PARAMETERS
//  pckg_sz    16     packet width; dest ID = D_push[pckg_sz-1 -: ID_W]
//  depth      8      FIFO entries; power of 2, >= 2
//  id         0      this port's ID, ID_W bits
//  broadcast  8'hFF  broadcast destination ID
// PORTS
//  clk          in   1                  bus clock, rising edge
//  reset        in   1                  synchronous, active-high
//  push         in   1                  bus delivers D_push this cycle
//  D_push       in   pckg_sz            packet from bus
//  rx_valid     out  1                  rx_data holds oldest buffered packet
//  rx_ready     in   1                  consumer takes rx_data when rx_valid
//  rx_data      out  pckg_sz            head-of-FIFO packet, ID included
//  rx_count     out  $clog2(depth)+1    occupancy, 0..depth
//  rx_full      out  1                  rx_count == depth
//  rx_overflow  out  1                  sticky: a matching packet was dropped
//  ovf_clr      in   1                  clears rx_overflow (and drop count)
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset is synchronous and active-high.
//  - Reset: pointers, rx_count, rx_overflow and rx_valid go to 0, rx_data
//    to 0, on the edge where reset=1. Reset mid-stream discards all entries.
//    Packets pushed in a reset cycle are ignored.
//  - match = push && (dst == id || dst == broadcast). Non-match: no state change.
//  - Write: match && (!rx_full || pop) -> mem[wr_ptr] <= D_push, wr_ptr++ mod depth.
//  - Pop: pop = rx_valid && rx_ready -> rd_ptr++ mod depth.
//  - rx_count: +1 on write only; -1 on pop only; unchanged on both or neither.
//  - Latency: packet matched at edge N -> rx_valid=1 after edge N if FIFO was
//    empty. rx_data = mem[rd_ptr]; rx_valid = (rx_count != 0).
//  - rx_data and rx_valid stay stable while rx_valid && !rx_ready.
//  - FIFO order is strict arrival order. Broadcast and unicast share the FIFO.
//  - Full + match + pop in the same cycle: accepted, no drop, count stays depth.
//  - Full + match, no pop: packet dropped, rx_overflow <= 1.
//  - ovf_clr: rx_overflow <= 0. A drop in the same cycle wins (flag stays 1).
//  - Empty + match + rx_ready: no bypass; the packet appears the next cycle.
// CONFIGURATION
//  BUS_RX_STATS_EN defined:
//   - adds port rx_drop_cnt (out, 16), a saturating count of dropped matches
//     (holds at 16'hFFFF);
//   - 0 on reset and on ovf_clr; a drop in the same cycle as ovf_clr loads 1.
//  BUS_RX_STATS_EN undefined: port and counter absent; all other behaviour
//  is identical.
// STRUCTURE
//  - Package bus_pkg holds:
//    - ID_W = 8 and BROADCAST_ID = 8'hFF;
//    - function get_dst(pkt) returning the dest ID;
//    - typedef bus_id_t.
//    Driver and monitor code import the same package.
//  - Sub-module rx_fifo #(width, depth): memory, pointers, count, full/empty,
//    simultaneous read/write.
//  - bus_rx_endpoint holds: address filter, overflow flag, optional stats
//    counter.
// TESTING (id=2, depth=8, pckg_sz=16)
//  1. push D_push=16'h02AB, rx_ready=0 -> next cycle rx_valid=1,
//     rx_data=16'h02AB, rx_count=1.
//  2. push 16'h03CD -> ignored; rx_count unchanged, no overflow.
//  3. push 16'hFF11 (broadcast) -> accepted; read out in order after 16'h02AB.
//  4. rx_ready=0, 9 pushes 16'h0201..16'h0209 ->
//     - rx_full=1, rx_overflow=1, rx_drop_cnt=1;
//     - drain yields 0201..0208.
//  5. FIFO full, rx_ready=1 and matching push in the same cycle -> accepted,
//     rx_count stays 8, no overflow.
//  6. reset=1 with 5 entries buffered -> next cycle rx_count=0, rx_valid=0,
//     rx_overflow=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: ID width, broadcast ID and destination extraction.
// Imported by the endpoint RTL and by bus driver/monitor code alike.
package bus_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned PKT_MAX_W = 64;

  typedef logic [ID_W-1:0] bus_id_t;

  localparam bus_id_t BROADCAST_ID = 8'hFF;

  // Destination ID sits in the top ID_W bits of a pkt_w-bit packet; callers
  // zero-extend their packet to PKT_MAX_W before calling.
  function automatic bus_id_t get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                      input int unsigned          pkt_w);
    return bus_id_t'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with head-of-queue read port, occupancy count and
// simultaneous read/write. Caller only asserts rd_en when not empty.
module rx_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [width-1:0]           rd_data,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Memory is cleared on reset so the head-of-queue output reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(depth));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/bus_rx_endpoint.sv
// Bus receive endpoint: address filter, FIFO buffering, sticky overflow flag.
// Define BUS_RX_STATS_EN to add the saturating rx_drop_cnt output.
module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter bus_id_t     id        = 8'h00,
  parameter bus_id_t     broadcast = BROADCAST_ID
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [pckg_sz-1:0]      D_push,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [pckg_sz-1:0]      rx_data,
  output logic [$clog2(depth):0]  rx_count,
  output logic                    rx_full,
  output logic                    rx_overflow,
  input  logic                    ovf_clr
`ifdef BUS_RX_STATS_EN
  ,
  output logic [15:0]             rx_drop_cnt
`endif
);

  bus_id_t dst;
  logic    match;
  logic    pop;
  logic    wr_en;
  logic    drop;
  logic    empty;
  logic    overflow_q, overflow_d;

  assign dst   = get_dst(PKT_MAX_W'(D_push), pckg_sz);
  assign match = push && ((dst == id) || (dst == broadcast));
  assign pop   = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = match && (!rx_full || pop);
  assign drop  = match && rx_full && !pop;

  rx_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (D_push),
    .rd_en   (pop),
    .rd_data (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (empty)
  );

  assign rx_valid = !empty;

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign rx_overflow = overflow_q;

`ifdef BUS_RX_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Clear restarts the count, so a drop coinciding with it counts as the first.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Bench for bus_rx_endpoint (id=2, depth=8, pckg_sz=16): directed vector
// table followed by randomized traffic checked against a queue model.
module tb_bus_rx_endpoint;
  import bus_pkg::*;

  localparam bus_id_t MY_ID = 8'h02;

  logic        clk = 1'b0;
  logic        reset, push, rx_ready, ovf_clr;
  logic [15:0] D_push;
  logic        rx_valid, rx_full, rx_overflow;
  logic [15:0] rx_data;
  logic [3:0]  rx_count;
`ifdef BUS_RX_STATS_EN
  logic [15:0] rx_drop_cnt;
`endif

  always #5 clk = ~clk;

  bus_rx_endpoint #(
    .pckg_sz   (16),
    .depth     (8),
    .id        (MY_ID),
    .broadcast (BROADCAST_ID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .D_push      (D_push),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_count    (rx_count),
    .rx_full     (rx_full),
    .rx_overflow (rx_overflow),
    .ovf_clr     (ovf_clr)
`ifdef BUS_RX_STATS_EN
    ,
    .rx_drop_cnt (rx_drop_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        push;
    logic [15:0] d;
    logic        rdy;
    logic        clr;
    logic [3:0]  cnt;
    logic        v;
    logic [15:0] data;
    logic        chkd;
    logic        full;
    logic        ovf;
    logic [15:0] drops;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic p, input logic [15:0] d,
                              input logic rdy, input logic clr, input logic [3:0] cnt,
                              input logic v, input logic [15:0] data, input logic chkd,
                              input logic full, input logic ovf, input logic [15:0] drops);
    vec_t e;
    e.rst = rst; e.push = p; e.d = d; e.rdy = rdy; e.clr = clr;
    e.cnt = cnt; e.v = v; e.data = data; e.chkd = chkd;
    e.full = full; e.ovf = ovf; e.drops = drops;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are applied, then sampled 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic p, input logic [15:0] d,
                      input logic rdy, input logic clr);
    reset = rst; push = p; D_push = d; rx_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: packet queue plus flag and drop counter.
  logic [15:0] m_q[$];
  logic        m_ovf;
  int unsigned m_drops;

  task automatic model(input logic rst, input logic p, input logic [15:0] d,
                       input logic rdy, input logic clr);
    bit do_pop, is_match, accept, dropped;
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      do_pop   = (m_q.size() != 0) && rdy;
      is_match = p && ((d[15:8] == MY_ID) || (d[15:8] == BROADCAST_ID));
      if (do_pop) void'(m_q.pop_front());
      accept  = is_match && (m_q.size() < 8);
      dropped = is_match && !accept;
      if (accept) m_q.push_back(d);
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) m_drops = dropped ? 1 : 0;
      else if (dropped && m_drops != 65535) m_drops++;
    end
  endtask

  initial begin
    vec_t        e;
    logic        r_rst, r_push, r_rdy, r_clr;
    logic [15:0] r_d;
    logic [7:0]  r_dst;
    int unsigned sel;

    reset = 1'b1; push = 1'b0; D_push = '0; rx_ready = 1'b0; ovf_clr = 1'b0;

    //   rst push d        rdy clr  cnt v data     chkd full ovf drops
    add(1, 0, 16'h0000, 0, 0,   0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 16'h02AB, 0, 0,   1, 1, 16'h02AB, 1, 0, 0, 0);
    add(0, 1, 16'h03CD, 0, 0,   1, 1, 16'h02AB, 1, 0, 0, 0);
    add(0, 1, 16'hFF11, 0, 0,   2, 1, 16'h02AB, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0,   1, 1, 16'hFF11, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0,   0, 0, 16'h0000, 0, 0, 0, 0);
    for (int unsigned k = 0; k < 8; k++)
      add(0, 1, 16'h0201 + 16'(k), 0, 0, 4'(k + 1), 1, 16'h0201, 1, k == 7, 0, 0);
    add(0, 1, 16'h0209, 0, 0,   8, 1, 16'h0201, 1, 1, 1, 1);
    add(0, 1, 16'h020A, 1, 0,   8, 1, 16'h0202, 1, 1, 1, 1);
    add(0, 0, 16'h0000, 0, 1,   8, 1, 16'h0202, 1, 1, 0, 0);
    add(0, 1, 16'h0211, 0, 1,   8, 1, 16'h0202, 1, 1, 1, 1);
    add(0, 1, 16'h03FF, 0, 0,   8, 1, 16'h0202, 1, 1, 1, 1);
    add(0, 0, 16'h0000, 1, 0,   7, 1, 16'h0203, 1, 0, 1, 1);
    add(0, 0, 16'h0000, 1, 0,   6, 1, 16'h0204, 1, 0, 1, 1);
    add(0, 0, 16'h0000, 1, 0,   5, 1, 16'h0205, 1, 0, 1, 1);
    add(1, 1, 16'h0222, 1, 0,   0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 1, 16'h0233, 1, 0,   1, 1, 16'h0233, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0,   0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 16'hFF44, 0, 0,   1, 1, 16'hFF44, 1, 0, 0, 0);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      e = vecs[i];
      step(e.rst, e.push, e.d, e.rdy, e.clr);
      chk($sformatf("vec%0d rx_count", i), 32'(rx_count), 32'(e.cnt));
      chk($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(e.v));
      chk($sformatf("vec%0d rx_full", i), 32'(rx_full), 32'(e.full));
      chk($sformatf("vec%0d rx_overflow", i), 32'(rx_overflow), 32'(e.ovf));
      if (e.chkd) chk($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(e.data));
`ifdef BUS_RX_STATS_EN
      chk($sformatf("vec%0d rx_drop_cnt", i), 32'(rx_drop_cnt), 32'(e.drops));
`endif
    end

    // Data held stable while valid and not ready.
    step(0, 0, 16'h0000, 0, 0);
    chk("hold rx_data", 32'(rx_data), 32'h0000FF44);
    chk("hold rx_valid", 32'(rx_valid), 32'h1);

    for (int unsigned i = 0; i < 3000; i++) begin
      r_rst  = (i == 0) || ($urandom_range(0, 99) == 0);
      r_push = ($urandom_range(0, 9) < 6);
      sel    = $urandom_range(0, 3);
      r_dst  = (sel < 2) ? MY_ID : (sel == 2) ? BROADCAST_ID : 8'($urandom);
      r_d    = {r_dst, 8'($urandom)};
      r_rdy  = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      r_clr  = ($urandom_range(0, 29) == 0);
      step(r_rst, r_push, r_d, r_rdy, r_clr);
      model(r_rst, r_push, r_d, r_rdy, r_clr);
      chk($sformatf("rnd%0d rx_count", i), 32'(rx_count), 32'(m_q.size()));
      chk($sformatf("rnd%0d rx_valid", i), 32'(rx_valid), 32'(m_q.size() != 0));
      chk($sformatf("rnd%0d rx_full", i), 32'(rx_full), 32'(m_q.size() == 8));
      chk($sformatf("rnd%0d rx_overflow", i), 32'(rx_overflow), 32'(m_ovf));
      if (m_q.size() != 0) chk($sformatf("rnd%0d rx_data", i), 32'(rx_data), 32'(m_q[0]));
`ifdef BUS_RX_STATS_EN
      chk($sformatf("rnd%0d rx_drop_cnt", i), 32'(rx_drop_cnt), m_drops);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
